// File: rtl/fft_reorder_buf_if.sv
// Handshake bundle for fft_reorder_buf: bit-reversed input stream, natural-order output stream.
// Optional sop_err signal exists only when FFT_REORDER_SOP_CHK_EN is defined.
interface fft_reorder_buf_if #(
    parameter int unsigned W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_sop;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_sop;
    logic         out_eop;
`ifdef FFT_REORDER_SOP_CHK_EN
    logic         sop_err;
`endif

    // Producer/consumer side (drives input stream, accepts output stream).
    modport master (
        output in_valid, in_data, in_sop, out_ready,
        input  in_ready, out_valid, out_data, out_sop, out_eop
`ifdef FFT_REORDER_SOP_CHK_EN
        , input sop_err
`endif
    );

    // Reorder buffer side.
    modport slave (
        input  in_valid, in_data, in_sop, out_ready,
        output in_ready, out_valid, out_data, out_sop, out_eop
`ifdef FFT_REORDER_SOP_CHK_EN
        , output sop_err
`endif
    );
endinterface

// File: rtl/fft_reorder_buf.sv
// FFT output reorder buffer: two ping-pong banks of N = 2^LOG2N samples. Writes land at the
// bit-reversed address of the running input count, reads walk the bank linearly, so frames leave
// in natural order while the other bank fills.
// Optional feature macro: FFT_REORDER_SOP_CHK_EN (in_sop framing check, adds sop_err).
module fft_reorder_buf #(
    parameter int unsigned W     = 32,
    parameter int unsigned LOG2N = 6
) (
    input logic            clk,
    input logic            rst_n,
    fft_reorder_buf_if.slave bus
);
    localparam int unsigned N = 1 << LOG2N;

    typedef logic [LOG2N-1:0] cnt_t;
    localparam cnt_t CntMax = '1;

    function automatic cnt_t bitrev(input cnt_t x);
        cnt_t r;
        for (int i = 0; i < int'(LOG2N); i++) begin
            r[i] = x[int'(LOG2N) - 1 - i];
        end
        return r;
    endfunction

    logic [W-1:0] mem_q [2][N];

    logic       wbank_q, wbank_d;
    logic       rbank_q, rbank_d;
    cnt_t       wcnt_q, wcnt_d;
    cnt_t       rcnt_q, rcnt_d;
    logic [1:0] full_q, full_d;

    logic wr_acc, rd_acc, restart;
    cnt_t waddr;

    assign bus.in_ready  = !full_q[wbank_q];
    assign bus.out_valid = full_q[rbank_q];
    assign bus.out_data  = bus.out_valid ? mem_q[rbank_q][rcnt_q] : '0;
    assign bus.out_sop   = bus.out_valid && (rcnt_q == '0);
    assign bus.out_eop   = bus.out_valid && (rcnt_q == CntMax);

    assign wr_acc = bus.in_valid && bus.in_ready;
    assign rd_acc = bus.out_valid && bus.out_ready;

`ifdef FFT_REORDER_SOP_CHK_EN
    logic sop_err_q, sop_err_d;

    // A start-of-frame marker arriving mid-frame abandons the partial frame.
    assign restart     = bus.in_sop && (wcnt_q != '0);
    assign sop_err_d   = wr_acc && restart;
    assign bus.sop_err = sop_err_q;

    // One-cycle error pulse following the offending accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sop_err_q <= 1'b0;
        end else begin
            sop_err_q <= sop_err_d;
        end
    end
`else
    logic unused_in_sop;
    assign unused_in_sop = bus.in_sop;
    assign restart       = 1'b0;
`endif

    // Next-state for counters, bank pointers and full flags; read and write complete always
    // touch different banks, so both full-flag updates can apply in the same cycle.
    always_comb begin
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        full_d  = full_q;
        waddr   = bitrev(wcnt_q);

        if (rd_acc) begin
            rcnt_d = rcnt_q + cnt_t'(1);
            if (rcnt_q == CntMax) begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
            end
        end

        if (wr_acc) begin
            if (restart) begin
                waddr  = '0;
                wcnt_d = cnt_t'(1);
            end else begin
                wcnt_d = wcnt_q + cnt_t'(1);
                if (wcnt_q == CntMax) begin
                    full_d[wbank_q] = 1'b1;
                    wbank_d         = ~wbank_q;
                end
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            full_q  <= 2'b00;
        end else begin
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            full_q  <= full_d;
        end
    end

    // Sample storage; deliberately not reset, full flags gate its visibility.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wbank_q][waddr] <= bus.in_data;
        end
    end
endmodule

// File: tb/tb_fft_reorder_buf.sv
// Directed self-checking bench for fft_reorder_buf with LOG2N=3 (N=8), W=16.
// Define FFT_REORDER_SOP_CHK_EN to also exercise the framing check.
module tb_fft_reorder_buf;
    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    fft_reorder_buf_if #(.W(16)) bus ();

    fft_reorder_buf #(.W(16), .LOG2N(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int bitrev3(input int x);
        return {29'd0, x[0], x[1], x[2]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_sop    = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Stimulus only: one frame in bit-reversed order, value = base + natural index.
    task automatic send_frame(input logic [15:0] base, input bit sop_first);
        for (int c = 0; c < 8; c++) begin
            bus.in_valid = 1'b1;
            bus.in_sop   = sop_first && (c == 0);
            bus.in_data  = base + 16'(bitrev3(c));
            step();
        end
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
    endtask

    task automatic test_reset();
        logic [19:0] got;
        do_reset();
        got = {bus.in_ready, bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data};
        n_cmp++;
        if (got !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want %h", got, {4'b1000, 16'h0});
        end
`ifdef FFT_REORDER_SOP_CHK_EN
        n_cmp++;
        if (bus.sop_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_sop_err: got %b want 0", bus.sop_err);
        end
`endif
    endtask

    task automatic test_single_frame();
        logic [18:0] got, exp;
        do_reset();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(bitrev3(c));
            n_cmp++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL single_fill c=%0d: out_valid=%b in_ready=%b want 0/1",
                         c, bus.out_valid, bus.in_ready);
            end
            step();
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            got = {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data};
            exp = {1'b1, k == 0, k == 7, 16'(k)};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL single_out k=%0d: got %h want %h", k, got, exp);
            end
            step();
        end
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_end: out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_streaming();
        int sent = 0;
        int got = 0;
        bit seen = 0;
        logic [15:0] exp;
        do_reset();
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && got < 32; cyc++) begin
            if (sent < 32) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 16'((sent / 8) * 16 + bitrev3(sent % 8));
                n_cmp++;
                if (bus.in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL stream_in_ready cyc=%0d: got %b want 1", cyc, bus.in_ready);
                end
            end else begin
                bus.in_valid = 1'b0;
            end
            if (seen) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL stream_gap cyc=%0d: out_valid=%b want 1", cyc, bus.out_valid);
                end
            end
            if (bus.out_valid === 1'b1) begin
                seen = 1;
                exp  = 16'((got / 8) * 16 + got % 8);
                n_cmp++;
                if (bus.out_data !== exp) begin
                    n_err++;
                    $display("FAIL stream_data idx=%0d: got %h want %h", got, bus.out_data, exp);
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            step();
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (got != 32) begin
            n_err++;
            $display("FAIL stream_count: got %0d outputs want 32", got);
        end
    endtask

    task automatic test_back_pressure();
        logic [18:0] got, exp;
        do_reset();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = (c < 8 ? 16'h0100 : 16'h0200) + 16'(bitrev3(c % 8));
            n_cmp++;
            if (bus.in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL bp_fill c=%0d: in_ready=%b want 1", c, bus.in_ready);
            end
            step();
        end
        // Both banks full: offered junk must be ignored while output holds index 0.
        for (int s = 0; s < 3; s++) begin
            bus.in_data = 16'hDEAD;
            got = {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data};
            n_cmp++;
            if (bus.in_ready !== 1'b0 || got !== {3'b110, 16'h0100}) begin
                n_err++;
                $display("FAIL bp_stall s=%0d: in_ready=%b out=%h want 0 / %h",
                         s, bus.in_ready, got, {3'b110, 16'h0100});
            end
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            got = {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data};
            exp = {1'b1, k == 0, k == 7, 16'h0100 + 16'(k)};
            n_cmp++;
            if (got !== exp || bus.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_drain_a k=%0d: out=%h in_ready=%b want %h / 0",
                         k, got, bus.in_ready, exp);
            end
            step();
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_ready_return: in_ready=%b want 1", bus.in_ready);
        end
        for (int k = 0; k < 8; k++) begin
            got = {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data};
            exp = {1'b1, k == 0, k == 7, 16'h0200 + 16'(k)};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL bp_drain_b k=%0d: got %h want %h", k, got, exp);
            end
            step();
        end
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_end: out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_q[$];
        logic [15:0] fr[8];
        logic [15:0] exp;
        int sent = 0;
        int recv = 0;
        int gen_frame = -1;
        bit acc_in, acc_out;
        do_reset();
        for (int cyc = 0; cyc < 20000 && recv < 800; cyc++) begin
            if (sent < 800 && $urandom_range(0, 1) == 1) begin
                if (sent / 8 != gen_frame) begin
                    gen_frame = sent / 8;
                    for (int i = 0; i < 8; i++) begin
                        fr[i] = 16'($urandom);
                        exp_q.push_back(fr[i]);
                    end
                end
                bus.in_valid = 1'b1;
                bus.in_data  = fr[bitrev3(sent % 8)];
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 1) == 1);
            acc_in  = bus.in_valid && bus.in_ready;
            acc_out = bus.out_valid && bus.out_ready;
            if (acc_out) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                n_cmp++;
                if (bus.out_data !== exp) begin
                    n_err++;
                    $display("FAIL rand_data idx=%0d: got %h want %h", recv, bus.out_data, exp);
                end
                recv++;
            end
            if (acc_in) sent++;
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        n_cmp++;
        if (recv != 800 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rand_count: recv=%0d pending=%0d want 800/0", recv, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [19:0] got;
        logic [18:0] o, exp;
        do_reset();
        send_frame(16'h0300, 1'b0);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h0400 + 16'(bitrev3(c));
            step();
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pre: out_valid=%b want 1", bus.out_valid);
        end
        rst_n = 1'b0;
        #1;
        got = {bus.in_ready, bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data};
        n_cmp++;
        if (got !== {4'b1000, 16'h0}) begin
            n_err++;
            $display("FAIL rst_async: got %h want %h", got, {4'b1000, 16'h0});
        end
        step();
        rst_n = 1'b1;
        step();
        bus.out_ready = 1'b1;
        send_frame(16'h0500, 1'b0);
        for (int k = 0; k < 8; k++) begin
            o   = {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data};
            exp = {1'b1, k == 0, k == 7, 16'h0500 + 16'(k)};
            n_cmp++;
            if (o !== exp) begin
                n_err++;
                $display("FAIL rst_after k=%0d: got %h want %h", k, o, exp);
            end
            step();
        end
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_residue: out_valid=%b want 0", bus.out_valid);
        end
    endtask

`ifdef FFT_REORDER_SOP_CHK_EN
    task automatic test_sop_chk();
        logic [18:0] o, exp;
        do_reset();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = 1'b1;
            bus.in_sop   = (c == 0);
            bus.in_data  = 16'h0E00 + 16'(c);
            step();
        end
        for (int c = 0; c < 8; c++) begin
            bus.in_valid = 1'b1;
            bus.in_sop   = (c == 0);
            bus.in_data  = 16'h0600 + 16'(bitrev3(c));
            step();
            if (c < 2) begin
                n_cmp++;
                if (bus.sop_err !== (c == 0)) begin
                    n_err++;
                    $display("FAIL sop_err_pulse c=%0d: got %b want %b", c, bus.sop_err, c == 0);
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            o   = {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data};
            exp = {1'b1, k == 0, k == 7, 16'h0600 + 16'(k)};
            n_cmp++;
            if (o !== exp) begin
                n_err++;
                $display("FAIL sop_out k=%0d: got %h want %h", k, o, exp);
            end
            step();
        end
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL sop_end: out_valid=%b want 0", bus.out_valid);
        end
    endtask
`endif

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sop    = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_streaming();
        test_back_pressure();
        test_random();
        test_reset_mid_frame();
`ifdef FFT_REORDER_SOP_CHK_EN
        test_sop_chk();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fft_reorder_buf.md
Name: fft_reorder_buf

Overview:
- Output-side reorder buffer for the streaming FFT pipeline.
- Accepts one frame of N samples in bit-reversed order from the last butterfly stage and emits the frame in natural order (index 0..N-1).
- Ping-pong storage: one bank fills while the other drains, so throughput is continuous.
- Input and output use valid/ready handshakes, so downstream back-pressure propagates to the pipeline.

Parameters:
- W, 32, sample width in bits (packed complex: {re, im}).
- LOG2N, 6, log2 of frame length; N = 2^LOG2N. Legal range is 2..10.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- in_valid  in  1  input sample valid.
- in_ready  out  1  buffer can accept a sample this cycle.
- in_data  in  W  input sample, bit-reversed frame order.
- in_sop  in  1  first sample of frame; used only with FFT_REORDER_SOP_CHK_EN.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the sample.
- out_data  out  W  output sample, natural order.
- out_sop  out  1  high with output index 0.
- out_eop  out  1  high with output index N-1.

Behaviour:
Storage and state:
- Two banks of N x W registers, mem[0] and mem[1]. Storage is not reset.
- State: wbank, rbank (1 bit each), wcnt, rcnt (LOG2N bits each), full[1:0].
- Reset values: wbank=rbank=0, wcnt=rcnt=0, full=2'b00.
- Reset outputs: in_ready=1, out_valid=0, out_sop=0, out_eop=0, out_data=0.

Write side:
- in_ready = !full[wbank], combinational from registers. There is no path from in_valid or out_ready.
- Write accept = in_valid && in_ready: mem[wbank][bitrev(wcnt)] <= in_data; wcnt <= wcnt+1.
- On accept with wcnt==N-1: full[wbank] <= 1, wbank toggles, wcnt wraps to 0.

Read side:
- out_valid = full[rbank].
- out_data = mem[rbank][rcnt] when out_valid, else 0.
- out_sop = out_valid && rcnt==0; out_eop = out_valid && rcnt==N-1.
- Read accept = out_valid && out_ready: rcnt <= rcnt+1.
- On read accept with rcnt==N-1: full[rbank] <= 0, rbank toggles, rcnt wraps to 0.

Timing and boundaries:
- Latency: out_valid for a frame rises the cycle after that frame's last input sample is accepted. The first output is index 0.
- Both banks full: in_ready=0 and input stalls. in_data is not sampled while in_ready=0.
- Simultaneous write-complete and read-complete: these always target different banks, and both full flags update in the same cycle.
- A freed bank becomes writable the cycle after it is freed; there is no same-cycle bypass.
- out_valid stays high and out_data stays stable while out_ready=0.
- Reset mid-frame: the partial frame and any full banks are discarded. After reset the block behaves as if freshly reset.
- bitrev(x) reverses the LOG2N bits of x.

Optional Feature:
Macro FFT_REORDER_SOP_CHK_EN.
- Defined:
  - Adds output port sop_err (1 bit, reset 0).
  - On a write accept with in_sop=1 and wcnt!=0, the partial frame is dropped: the sample is written to mem[wbank][0] and wcnt <= 1. full and wbank are unchanged.
  - sop_err pulses high for exactly one cycle, the cycle after that accept.
  - An accept with in_sop=0 and wcnt==0 is written normally; no error is raised.
- Not defined:
  - The sop_err port does not exist and in_sop is ignored.
  - Framing is purely by count.

Test Plan (LOG2N=3, N=8, W=16 unless noted):
1. Single frame: in_data = 0,4,2,6,1,5,3,7, one per cycle, out_ready=1 -> out_valid rises the cycle after the 8th accept. out_data = 0..7 on consecutive cycles. out_sop on 0, out_eop on 7.
2. Continuous streaming, 4 back-to-back frames, out_ready=1 -> in_ready never deasserts, no gaps in out_valid after the first frame, every frame in natural order.
3. Back-pressure: out_ready=0 while 2 frames are sent -> in_ready=0 after the 16th accept and out_data holds 0. Raising out_ready drains 0..7 then the second frame; in_ready returns the cycle after the first bank frees.
4. Random in_valid/out_ready (50%) over 100 frames of random data -> scoreboard matches natural-order permutation, no loss or duplication.
5. Reset asserted after 5 accepts -> outputs return to reset values immediately. The next full frame is reordered correctly with no residue.
6. With FFT_REORDER_SOP_CHK_EN: 3 samples, then in_sop=1 with a new frame of 8 -> sop_err one-cycle pulse; output is exactly the new frame in order 0..7.
